// File: rtl/axi3_sram_slave.sv
// AXI3 slave front-end for an on-chip SRAM. It serves one read burst or one
// write burst at a time. Read and write requests are arbitrated round-robin.
module axi3_sram_slave #(
    parameter int DEPTH_LOG2 = 14,
    parameter int ID_W       = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    // read address channel
    input  logic [ID_W-1:0]       axi_arid,
    input  logic [31:0]           axi_araddr,
    input  logic [7:0]            axi_arlen,
    input  logic [2:0]            axi_arsize,
    input  logic [1:0]            axi_arburst,
    input  logic [1:0]            axi_arlock,
    input  logic [3:0]            axi_arcache,
    input  logic [2:0]            axi_arprot,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    // read data channel
    output logic [ID_W-1:0]       axi_rid,
    output logic [31:0]           axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rlast,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    // write address channel
    input  logic [ID_W-1:0]       axi_awid,
    input  logic [31:0]           axi_awaddr,
    input  logic [7:0]            axi_awlen,
    input  logic [2:0]            axi_awsize,
    input  logic [1:0]            axi_awburst,
    input  logic [1:0]            axi_awlock,
    input  logic [3:0]            axi_awcache,
    input  logic [2:0]            axi_awprot,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    // write data channel
    input  logic [ID_W-1:0]       axi_wid,
    input  logic [31:0]           axi_wdata,
    input  logic [3:0]            axi_wstrb,
    input  logic                  axi_wlast,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    // write response channel
    output logic [ID_W-1:0]       axi_bid,
    output logic [1:0]            axi_bresp,
    output logic                  axi_bvalid,
    input  logic                  axi_bready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, RD, WR_DATA, WR_RESP} state_t;

    state_t                state_q, state_d;
    logic                  prio_q;
    logic [ID_W-1:0]       id_q;
    logic [31:0]           addr_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt_q;
    logic [1:0]            burst_q;
    logic                  err_q;
    logic [31:0]           rd_q;
    logic [31:0]           mem [DEPTH];

    logic                  grant_rd, grant_wr;
    logic                  ar_hs, aw_hs, r_hs, w_hs, b_hs;
    logic                  is_last, wid_ok, mem_we, rd_en;
    logic [31:0]           next_addr;
    logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
    logic                  unused_ok;

    // Address of the following beat; WRAP stays inside the (len+1)*4 byte window.
    function automatic logic [31:0] beat_next(input logic [31:0] a, input logic [1:0] b,
                                              input logic [7:0] l);
        logic [31:0] mask;
        mask = {22'd0, l, 2'b11};
        case (b)
            2'b00:   beat_next = a;
            2'b10:   beat_next = (a & ~mask) | ((a + 32'd4) & mask);
            default: beat_next = a + 32'd4;
        endcase
    endfunction

    function automatic logic wrap_len_ok(input logic [7:0] l);
        return (l == 8'd1) || (l == 8'd3) || (l == 8'd7) || (l == 8'd15);
    endfunction

    assign unused_ok = ^{axi_arlock, axi_arcache, axi_arprot,
                         axi_awlock, axi_awcache, axi_awprot};

    assign grant_rd  = axi_arvalid & (~axi_awvalid | ~prio_q);
    assign grant_wr  = axi_awvalid & (~axi_arvalid |  prio_q);
    assign ar_hs     = axi_arvalid & axi_arready;
    assign aw_hs     = axi_awvalid & axi_awready;
    assign r_hs      = axi_rvalid  & axi_rready;
    assign w_hs      = axi_wvalid  & axi_wready;
    assign b_hs      = axi_bvalid  & axi_bready;
    assign is_last   = (cnt_q == len_q);
    assign wid_ok    = (axi_wid == id_q);
    assign mem_we    = w_hs & ~err_q & wid_ok;
    assign rd_en     = ar_hs | r_hs;
    assign next_addr = beat_next(addr_q, burst_q, len_q);
    assign rd_idx    = ar_hs ? axi_araddr[DEPTH_LOG2+1:2] : next_addr[DEPTH_LOG2+1:2];
    assign wr_idx    = addr_q[DEPTH_LOG2+1:2];

    assign axi_rid   = (state_q == RD) ? id_q : '0;
    assign axi_rdata = (state_q == RD && !err_q) ? rd_q : 32'd0;
    assign axi_rresp = (state_q == RD && err_q) ? 2'b10 : 2'b00;
    assign axi_rlast = (state_q == RD) & is_last;
    assign axi_bid   = (state_q == WR_RESP) ? id_q : '0;
    assign axi_bresp = (state_q == WR_RESP && err_q) ? 2'b10 : 2'b00;

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode and channel handshake outputs.
    always_comb begin
        state_d     = state_q;
        axi_arready = 1'b0;
        axi_awready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        case (state_q)
            IDLE: begin
                axi_arready = grant_rd;
                axi_awready = grant_wr;
                if (grant_rd)      state_d = RD;
                else if (grant_wr) state_d = WR_DATA;
            end
            RD: begin
                axi_rvalid = 1'b1;
                if (axi_rready && is_last) state_d = IDLE;
            end
            WR_DATA: begin
                axi_wready = 1'b1;
                if (axi_wvalid && is_last) state_d = WR_RESP;
            end
            WR_RESP: begin
                axi_bvalid = 1'b1;
                if (axi_bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst bookkeeping: latched request, beat counter, error flag, arbitration priority.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            prio_q  <= 1'b0;
            id_q    <= '0;
            addr_q  <= 32'd0;
            len_q   <= 8'd0;
            burst_q <= 2'b00;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else if (ar_hs) begin
            id_q    <= axi_arid;
            addr_q  <= axi_araddr;
            len_q   <= axi_arlen;
            burst_q <= axi_arburst;
            cnt_q   <= 8'd0;
            err_q   <= (axi_arsize != 3'd2) | (axi_arburst == 2'b11) |
                       ((axi_arburst == 2'b10) & ~wrap_len_ok(axi_arlen));
        end else if (aw_hs) begin
            id_q    <= axi_awid;
            addr_q  <= axi_awaddr;
            len_q   <= axi_awlen;
            burst_q <= axi_awburst;
            cnt_q   <= 8'd0;
            err_q   <= (axi_awsize != 3'd2) | (axi_awburst == 2'b11) |
                       ((axi_awburst == 2'b10) & ~wrap_len_ok(axi_awlen));
        end else if (r_hs) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= next_addr;
            if (is_last) prio_q <= 1'b1;
        end else if (w_hs) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= next_addr;
            err_q  <= err_q | ~wid_ok | (axi_wlast != is_last);
        end else if (b_hs) begin
            prio_q <= 1'b0;
        end
    end

    // SRAM array with byte-enable writes and a registered read port.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (axi_wstrb[b]) mem[wr_idx][b*8 +: 8] <= axi_wdata[b*8 +: 8];
            end
        end
        if (rd_en) rd_q <= mem[rd_idx];
    end

endmodule

// File: tb/tb_axi3_sram_slave.sv
// Directed bench for axi3_sram_slave: arbitration, bursts, errors, strobes, reset.
module tb_axi3_sram_slave;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  axi_arid, axi_awid, axi_wid, axi_rid, axi_bid;
    logic [31:0] axi_araddr, axi_awaddr, axi_wdata, axi_rdata;
    logic [7:0]  axi_arlen, axi_awlen;
    logic [2:0]  axi_arsize, axi_awsize;
    logic [1:0]  axi_arburst, axi_awburst, axi_rresp, axi_bresp;
    logic [3:0]  axi_wstrb;
    logic        axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;
    logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
    logic        axi_bvalid, axi_bready;

    int checks = 0;
    int failures = 0;

    axi3_sram_slave #(.DEPTH_LOG2(14), .ID_W(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(2'b00),
        .axi_arcache(4'h0), .axi_arprot(3'h0), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(2'b00),
        .axi_awcache(4'h0), .axi_awprot(3'h0), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready),
        .axi_wid(axi_wid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready)
    );

    // Free-running 100 MHz clock.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Presents an AR (is_wr=0) or AW (is_wr=1) request and waits for its handshake.
    task automatic applyStimulus(input bit is_wr, input logic [3:0] id, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst);
        @(negedge aclk);
        if (is_wr) begin
            axi_awid = id; axi_awaddr = addr; axi_awlen = len;
            axi_awsize = size; axi_awburst = burst; axi_awvalid = 1'b1;
            #1;
            for (int n = 0; n < 50 && !axi_awready; n++) @(negedge aclk);
            checkOutput("awready", 32'(axi_awready), 32'd1);
        end else begin
            axi_arid = id; axi_araddr = addr; axi_arlen = len;
            axi_arsize = size; axi_arburst = burst; axi_arvalid = 1'b1;
            #1;
            for (int n = 0; n < 50 && !axi_arready; n++) @(negedge aclk);
            checkOutput("arready", 32'(axi_arready), 32'd1);
        end
        @(posedge aclk);
        #1;
        axi_awvalid = 1'b0;
        axi_arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                          input logic last, input string tag);
        @(negedge aclk);
        axi_wid = id; axi_wdata = data; axi_wstrb = strb; axi_wlast = last; axi_wvalid = 1'b1;
        #1;
        for (int n = 0; n < 50 && !axi_wready; n++) @(negedge aclk);
        checkOutput({tag, "_wready"}, 32'(axi_wready), 32'd1);
        @(posedge aclk);
        #1 axi_wvalid = 1'b0;
    endtask

    // Takes one R beat; with stall set, first holds rready low for a cycle.
    task automatic recv_r(input bit stall, input logic [31:0] data, input logic last,
                          input logic [1:0] resp, input logic [3:0] id, input string tag);
        @(negedge aclk);
        if (stall) begin
            axi_rready = 1'b0;
            for (int n = 0; n < 50 && !axi_rvalid; n++) @(negedge aclk);
            checkOutput({tag, "_hold"}, axi_rdata, data);
            @(negedge aclk);
        end
        axi_rready = 1'b1;
        #1;
        for (int n = 0; n < 50 && !axi_rvalid; n++) @(negedge aclk);
        checkOutput({tag, "_rvalid"}, 32'(axi_rvalid), 32'd1);
        checkOutput({tag, "_rdata"}, axi_rdata, data);
        checkOutput({tag, "_rlast"}, 32'(axi_rlast), 32'(last));
        checkOutput({tag, "_rresp"}, 32'(axi_rresp), 32'(resp));
        checkOutput({tag, "_rid"}, 32'(axi_rid), 32'(id));
        @(posedge aclk);
        #1 axi_rready = 1'b0;
    endtask

    task automatic recv_b(input logic [3:0] id, input logic [1:0] resp, input string tag);
        @(negedge aclk);
        axi_bready = 1'b1;
        #1;
        for (int n = 0; n < 50 && !axi_bvalid; n++) @(negedge aclk);
        checkOutput({tag, "_bvalid"}, 32'(axi_bvalid), 32'd1);
        checkOutput({tag, "_bresp"}, 32'(axi_bresp), 32'(resp));
        checkOutput({tag, "_bid"}, 32'(axi_bid), 32'(id));
        @(posedge aclk);
        #1 axi_bready = 1'b0;
    endtask

    // Directed sequence of all scenarios.
    initial begin
        aresetn = 1'b0;
        axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = 3'd2; axi_arburst = 2'b01;
        axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = 3'd2; axi_awburst = 2'b01;
        axi_arvalid = 0; axi_awvalid = 0; axi_rready = 0; axi_bready = 0;
        axi_wid = '0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 0; axi_wvalid = 0;
        repeat (2) @(negedge aclk);
        checkOutput("rst_arready", 32'(axi_arready), 32'd0);
        checkOutput("rst_rvalid", 32'(axi_rvalid), 32'd0);
        checkOutput("rst_wready", 32'(axi_wready), 32'd0);
        checkOutput("rst_bvalid", 32'(axi_bvalid), 32'd0);
        checkOutput("rst_rdata", axi_rdata, 32'd0);
        aresetn = 1'b1;

        $display("[TB] arbitration");
        @(negedge aclk);
        axi_arid = 4'd1; axi_araddr = 32'h400; axi_arlen = 8'd0; axi_arvalid = 1'b1;
        axi_awid = 4'd2; axi_awaddr = 32'h404; axi_awlen = 8'd0; axi_awvalid = 1'b1;
        #1;
        checkOutput("arb1_arready", 32'(axi_arready), 32'd1);
        checkOutput("arb1_awready", 32'(axi_awready), 32'd0);
        @(posedge aclk);
        #1 axi_arvalid = 1'b0;
        @(negedge aclk);
        checkOutput("arb1_rvalid", 32'(axi_rvalid), 32'd1);
        checkOutput("arb1_rlast", 32'(axi_rlast), 32'd1);
        checkOutput("arb1_rid", 32'(axi_rid), 32'd1);
        checkOutput("arb1_awready_busy", 32'(axi_awready), 32'd0);
        axi_rready = 1'b1;
        @(posedge aclk);
        #1 axi_rready = 1'b0;
        @(negedge aclk);
        axi_arid = 4'd3; axi_araddr = 32'h404; axi_arvalid = 1'b1;
        #1;
        checkOutput("arb2_awready", 32'(axi_awready), 32'd1);
        checkOutput("arb2_arready", 32'(axi_arready), 32'd0);
        @(posedge aclk);
        #1 axi_awvalid = 1'b0;
        send_w(4'd2, 32'h11111111, 4'hF, 1'b1, "arb2_w");
        recv_b(4'd2, 2'b00, "arb2_b");
        applyStimulus(0, 4'd3, 32'h404, 8'd0, 3'd2, 2'b01);
        recv_r(0, 32'h11111111, 1, 2'b00, 4'd3, "arb2_r");

        $display("[TB] single write/read");
        applyStimulus(1, 4'd5, 32'h100, 8'd0, 3'd2, 2'b01);
        send_w(4'd5, 32'hDEADBEEF, 4'hF, 1'b1, "single_w");
        recv_b(4'd5, 2'b00, "single_b");
        applyStimulus(0, 4'd6, 32'h100, 8'd0, 3'd2, 2'b01);
        recv_r(0, 32'hDEADBEEF, 1, 2'b00, 4'd6, "single_r");

        $display("[TB] INCR burst with backpressure");
        applyStimulus(1, 4'd4, 32'h200, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) send_w(4'd4, 32'(i + 1), 4'hF, 1'(i == 3), "incr_w");
        recv_b(4'd4, 2'b00, "incr_b");
        applyStimulus(0, 4'd4, 32'h200, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) recv_r(1, 32'(i + 1), 1'(i == 3), 2'b00, 4'd4, "incr_r");

        $display("[TB] WRAP burst");
        applyStimulus(1, 4'd2, 32'h300, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) send_w(4'd2, 32'(10 + i), 4'hF, 1'(i == 3), "wrap_w");
        recv_b(4'd2, 2'b00, "wrap_b");
        applyStimulus(0, 4'd2, 32'h30C, 8'd3, 3'd2, 2'b10);
        recv_r(0, 32'hD, 0, 2'b00, 4'd2, "wrap_r0");
        recv_r(0, 32'hA, 0, 2'b00, 4'd2, "wrap_r1");
        recv_r(0, 32'hB, 0, 2'b00, 4'd2, "wrap_r2");
        recv_r(0, 32'hC, 1, 2'b00, 4'd2, "wrap_r3");

        $display("[TB] error cases");
        applyStimulus(0, 4'd1, 32'h200, 8'd1, 3'd1, 2'b01);
        recv_r(0, 32'd0, 0, 2'b10, 4'd1, "size_r0");
        recv_r(0, 32'd0, 1, 2'b10, 4'd1, "size_r1");
        applyStimulus(1, 4'd7, 32'h500, 8'd1, 3'd2, 2'b01);
        send_w(4'd7, 32'hAAAA0000, 4'hF, 1'b0, "pre_w0");
        send_w(4'd7, 32'hBBBB0000, 4'hF, 1'b1, "pre_w1");
        recv_b(4'd7, 2'b00, "pre_b");
        applyStimulus(1, 4'd7, 32'h500, 8'd1, 3'd2, 2'b01);
        send_w(4'd7, 32'h00000011, 4'hF, 1'b0, "wid_w0");
        send_w(4'd8, 32'h00000022, 4'hF, 1'b1, "wid_w1");
        recv_b(4'd7, 2'b10, "wid_b");
        applyStimulus(0, 4'd7, 32'h500, 8'd1, 3'd2, 2'b01);
        recv_r(0, 32'h00000011, 0, 2'b00, 4'd7, "wid_r0");
        recv_r(0, 32'hBBBB0000, 1, 2'b00, 4'd7, "wid_r1");
        applyStimulus(1, 4'd1, 32'h600, 8'd1, 3'd2, 2'b01);
        send_w(4'd1, 32'h5, 4'hF, 1'b1, "early_w0");
        send_w(4'd1, 32'h6, 4'hF, 1'b1, "early_w1");
        recv_b(4'd1, 2'b10, "early_b");

        $display("[TB] partial strobe");
        applyStimulus(1, 4'd3, 32'h700, 8'd0, 3'd2, 2'b01);
        send_w(4'd3, 32'hFFFFFFFF, 4'hF, 1'b1, "strb_w0");
        recv_b(4'd3, 2'b00, "strb_b0");
        applyStimulus(1, 4'd3, 32'h700, 8'd0, 3'd2, 2'b01);
        send_w(4'd3, 32'h12345678, 4'h3, 1'b1, "strb_w1");
        recv_b(4'd3, 2'b00, "strb_b1");
        applyStimulus(0, 4'd3, 32'h700, 8'd0, 3'd2, 2'b01);
        recv_r(0, 32'hFFFF5678, 1, 2'b00, 4'd3, "strb_r");

        $display("[TB] reset mid-burst");
        applyStimulus(1, 4'd9, 32'h800, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) send_w(4'd9, 32'hC0 + 32'(i), 4'hF, 1'(i == 3), "rstpre_w");
        recv_b(4'd9, 2'b00, "rstpre_b");
        applyStimulus(1, 4'd9, 32'h800, 8'd3, 3'd2, 2'b01);
        send_w(4'd9, 32'hE0, 4'hF, 1'b0, "rstmid_w0");
        send_w(4'd9, 32'hE1, 4'hF, 1'b0, "rstmid_w1");
        @(negedge aclk);
        aresetn = 1'b0;
        axi_wid = 4'd9; axi_wdata = 32'hEEEEEEEE; axi_wstrb = 4'hF; axi_wlast = 1'b0;
        axi_wvalid = 1'b1;
        #1;
        checkOutput("rstmid_wready", 32'(axi_wready), 32'd0);
        checkOutput("rstmid_bvalid", 32'(axi_bvalid), 32'd0);
        checkOutput("rstmid_awready", 32'(axi_awready), 32'd0);
        checkOutput("rstmid_bid", 32'(axi_bid), 32'd0);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        axi_wvalid = 1'b0;
        aresetn = 1'b1;
        applyStimulus(0, 4'd9, 32'h800, 8'd3, 3'd2, 2'b01);
        recv_r(0, 32'hE0, 0, 2'b00, 4'd9, "rstpost_r0");
        recv_r(0, 32'hE1, 0, 2'b00, 4'd9, "rstpost_r1");
        recv_r(0, 32'hC2, 0, 2'b00, 4'd9, "rstpost_r2");
        recv_r(0, 32'hC3, 1, 2'b00, 4'd9, "rstpost_r3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi3_sram_slave.md
# axi3_sram_slave

AXI3 slave block-RAM controller that sits directly downstream of the core's AXI3 master port and serves its instruction/data refills and write-backs from on-chip SRAM. One transaction is in service at a time: one read burst or one write burst. Read and write requests are arbitrated round-robin. It is used as the memory endpoint in simulation and in small FPGA builds.

## Interface
- DEPTH_LOG2, 14: log2 of SRAM depth in 32-bit words (default 64 KiB).
- ID_W, 4: AXI ID width.

Ports:
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- axi_arid/araddr/arlen/arsize/arburst  in  ID_W/32/8/3/2  read address
- axi_arvalid  in  1;  axi_arready  out  1
- axi_rid  out  ID_W;  axi_rdata  out  32;  axi_rresp  out  2;  axi_rlast  out  1;  axi_rvalid  out  1;  axi_rready  in  1
- axi_awid/awaddr/awlen/awsize/awburst  in  ID_W/32/8/3/2  write address
- axi_awvalid  in  1;  axi_awready  out  1
- axi_wid  in  ID_W;  axi_wdata  in  32;  axi_wstrb  in  4;  axi_wlast  in  1;  axi_wvalid  in  1;  axi_wready  out  1
- axi_bid  out  ID_W;  axi_bresp  out  2;  axi_bvalid  out  1;  axi_bready  in  1
- The lock, cache and prot inputs are accepted and ignored.

## Operation
- FSM states: IDLE, RD, WR_DATA, WR_RESP.
- Arbitration in IDLE:
  - grant = read if only arvalid is high; write if only awvalid is high.
  - If both are high, grant follows prio: read when prio=0, write when prio=1.
  - arready = IDLE & grant_read; awready = IDLE & grant_write. Both are combinational from the FSM and the valids.
  - prio is set to 1 after a completed read and to 0 after a completed write.
- Address latch: on handshake, store id, addr, len, size and burst. Beat counter cnt = 0. err = (size != 2) | (burst == 2'b11).
- Beat address:
  - FIXED (00): constant.
  - INCR (01): +4.
  - WRAP (10): +4, wrapping within the aligned (len+1)*4-byte window. WRAP with len not in {1,3,7,15} sets err.
- SRAM index: addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses alias.
- Read path (RD):
  - SRAM read port is addressed by the next-beat address. The read enable fires only on AR handshake or R handshake, so rdata is held under backpressure.
  - rvalid stays high in RD. rid = latched id. rlast = (cnt == len). rresp = err ? 2'b10 : 2'b00, and rdata = 0 when err.
  - On R handshake with rlast: go to IDLE.
- Write path (WR_DATA):
  - wready = 1 in WR_DATA.
  - On each W handshake: write the bytes enabled by wstrb to SRAM, unless err or wid != latched id (that beat is skipped).
  - Any of the following sets err: a wid mismatch, wlast == 1 with cnt != len, or wlast == 0 with cnt == len.
  - After the beat with cnt == len, go to WR_RESP whatever wlast is.
- WR_RESP: bvalid = 1, bid = latched id, bresp = err ? 2'b10 : 2'b00. On B handshake go to IDLE.
- Reset (asynchronous assertion, at any point including mid-burst):
  - State goes to IDLE, prio = 0, err = 0, cnt = 0.
  - All valid and ready outputs are 0; rdata, rid, bid and resp outputs are 0; rlast = 0.
  - A burst in progress is abandoned and no further SRAM writes occur. SRAM contents are not reset.

## Timing
- Read: AR handshake at edge T. The first rvalid is high in the cycle after T and carries the data of beat 0. With rready held high, one beat is returned per cycle, so a len=L burst finishes in L+1 cycles.
- After the rlast handshake at edge N: IDLE, so arready/awready can be high in cycle N+1. The minimum read-to-read gap is one idle cycle.
- Write: AW handshake at edge T. wready is high from cycle T+1, and each beat is written at its handshake edge.
- After the last beat at edge N: bvalid is high in cycle N+1 and held until bready. After the B handshake, the FSM is in IDLE in the next cycle.
- Throughput: one beat per cycle on R and W. There is no overlap between transactions, so read-after-write ordering is inherent.
- cnt is 8 bits. len=255 gives 256 beats and cnt does not overflow before termination.

## Test plan
- Single write then read: AW addr 0x100, len 0, wdata 0xDEADBEEF, wstrb 0xF -> bresp 00. Then AR 0x100 -> rdata 0xDEADBEEF, rlast=1, rresp 00.
- INCR burst of 4 at 0x200 writing 1,2,3,4, then a read burst with rready toggling every other cycle -> data 1,2,3,4 in order, rdata stable while stalled, rlast only on beat 3.
- WRAP burst, len 3, read starting at 0x30C after writing 0x300..0x30C with 0xA..0xD -> beats 0xD,0xA,0xB,0xC.
- arvalid and awvalid high in the same cycle after reset -> read granted first. Next simultaneous request -> write granted.
- Error cases:
  - arsize=1 -> every beat has rresp 10 and rdata 0.
  - wid mismatch on beat 1 of a 2-beat write -> beat 1 is not written, bresp 10.
  - wlast early on beat 0 of len 1 -> bresp 10.
- Partial strobe and reset:
  - wstrb 0x3 over 0xFFFFFFFF with data 0x12345678 -> read returns 0xFFFF5678.
  - aresetn pulsed low mid-burst during a 4-beat write after beat 1 -> outputs 0 immediately, beats 2-3 are never written, the next transaction is served normally.
